spi_flash_burst_reader: RTL and testbench

- Parametrised successor to the single-bit SPI EEPROM streamer.
- Issues a configurable read command, address and dummy phase to a serial flash or EEPROM.
- Assembles the MISO stream MSB-first into WORD_W-bit words.
- Ends a burst automatically after a programmed word count or on cancel, then enforces a minimum CS-high time before the next command.
- Feeds downstream loaders, such as the pattern/ROM fetch paths, word-at-a-time instead of bit-at-a-time.

---
 rtl/spi_flash_burst_reader.sv | 189 ++++++++++++++++++
 tb/tb_spi_flash_burst_reader.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_burst_reader.sv
// Burst reader for SPI flash/EEPROM: sends command, address and dummy cycles,
// then assembles MISO MSB-first into WORD_W-bit words until the length is reached or cancelled.
module spi_flash_burst_reader #(
    parameter int         ADDR_W         = 24,
    parameter logic [7:0] CMD            = 8'h03,
    parameter int         DUMMY_CYCLES   = 1,
    parameter int         WORD_W         = 32,
    parameter int         LEN_W          = 16,
    parameter int         CS_HIGH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] IN_addr,
    input  logic [LEN_W-1:0]  IN_len,
    input  logic              IN_read,
    input  logic              IN_cancel,
    output logic              OUT_ready,
    output logic              OUT_busy,
    output logic [WORD_W-1:0] OUT_word,
    output logic              OUT_word_valid,
    output logic              OUT_done,
    output logic              OUT_sclk,
    output logic              OUT_cs,
    output logic              OUT_mosi,
    input  logic              IN_miso
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_DUMMY = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_GUARD = 3'd5;

    localparam int TX_W    = 8 + ADDR_W;
    localparam int MAX_1   = (ADDR_W > WORD_W) ? ADDR_W : WORD_W;
    localparam int MAX_2   = (DUMMY_CYCLES > CS_HIGH_CYCLES) ? DUMMY_CYCLES : CS_HIGH_CYCLES;
    localparam int MAX_3   = (MAX_1 > MAX_2) ? MAX_1 : MAX_2;
    localparam int CNT_MAX = (MAX_3 > 8) ? MAX_3 : 8;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TX_W-1:0]   tx_q, tx_d;
    logic [WORD_W-1:0] rx_q, rx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  wcnt_q, wcnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              cs_q, cs_d;
    logic              mosi_q, mosi_d;
    logic              mosi_fall_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        word_d  = word_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (IN_read) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    tx_d    = {CMD, IN_addr};
                    len_d   = IN_len;
                    wcnt_d  = '0;
                end
            end
            S_CMD, S_ADDR: begin
                tx_d = tx_q << 1;
                if (IN_cancel) begin
                    state_d = S_GUARD;
                    cnt_d   = '0;
                end else if (state_q == S_CMD && cnt_q == CNT_W'(7)) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                end else if (state_q == S_ADDR && cnt_q == CNT_W'(ADDR_W - 1)) begin
                    state_d = S_DUMMY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DUMMY: begin
                if (IN_cancel) begin
                    state_d = S_GUARD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                rx_d = {rx_q[WORD_W-2:0], IN_miso};
                if (cnt_q == CNT_W'(WORD_W - 1)) begin
                    // A word completing on a cancel cycle is still delivered.
                    cnt_d   = '0;
                    word_d  = rx_d;
                    valid_d = 1'b1;
                    wcnt_d  = wcnt_q + LEN_W'(1);
                    if (len_q != '0 && wcnt_d == len_q) begin
                        done_d  = 1'b1;
                        state_d = S_GUARD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (IN_cancel) begin
                    state_d = S_GUARD;
                    cnt_d   = '0;
                end
            end
            S_GUARD: begin
                if (cnt_q == CNT_W'(CS_HIGH_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs for the cycle being entered are derived from the next state.
        cs_d   = !(state_d inside {S_CMD, S_ADDR, S_DUMMY, S_DATA});
        mosi_d = (state_d == S_CMD || state_d == S_ADDR) ? tx_d[TX_W-1] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            len_q   <= '0;
            wcnt_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
        end
    end

    // Half-cycle relaunch keeps MOSI stable around the flash's rising-edge sample point.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            mosi_fall_q <= 1'b0;
        end else begin
            mosi_fall_q <= mosi_q;
        end
    end

    assign OUT_ready      = (state_q == S_IDLE);
    assign OUT_busy       = (state_q != S_IDLE);
    assign OUT_word       = word_q;
    assign OUT_word_valid = valid_q;
    assign OUT_done       = done_q;
    assign OUT_sclk       = clk;
    assign OUT_cs         = cs_q;
    assign OUT_mosi       = mosi_fall_q;

endmodule

// File: tb/tb_spi_flash_burst_reader.sv
// Randomized bench for spi_flash_burst_reader: a behavioural flash drives MISO from a word
// table, and burst-level expectations (cs length, strobe times, words, done) come from the timing rules.
module tb_spi_flash_burst_reader;

    localparam int HDR   = 32;   // 8 command bits + 24 address bits
    localparam int GUARD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] in_addr;
    logic [15:0] in_len;
    logic        in_read, in_cancel, in_miso, sel;
    logic        read_a, read_b;

    logic        ready_a, busy_a, valid_a, done_a, sclk_a, cs_a, mosi_a;
    logic [31:0] word_a;
    logic        ready_b, busy_b, valid_b, done_b, sclk_b, cs_b, mosi_b;
    logic [7:0]  word_b;

    logic        obs_ready, obs_busy, obs_valid, obs_done, obs_cs, obs_mosi, obs_sclk;
    logic [31:0] obs_word;
    int          p_w, p_d;
    logic [7:0]  p_cmd;

    assign read_a    = in_read & ~sel;
    assign read_b    = in_read & sel;
    assign obs_ready = sel ? ready_b : ready_a;
    assign obs_busy  = sel ? busy_b  : busy_a;
    assign obs_valid = sel ? valid_b : valid_a;
    assign obs_done  = sel ? done_b  : done_a;
    assign obs_cs    = sel ? cs_b    : cs_a;
    assign obs_mosi  = sel ? mosi_b  : mosi_a;
    assign obs_sclk  = sel ? sclk_b  : sclk_a;
    assign obs_word  = sel ? {24'h0, word_b} : word_a;
    assign p_w       = sel ? 8 : 32;
    assign p_d       = sel ? 9 : 1;
    assign p_cmd     = sel ? 8'h0B : 8'h03;

    spi_flash_burst_reader dut_a (
        .clk(clk), .rst(rst), .IN_addr(in_addr), .IN_len(in_len), .IN_read(read_a),
        .IN_cancel(in_cancel), .OUT_ready(ready_a), .OUT_busy(busy_a), .OUT_word(word_a),
        .OUT_word_valid(valid_a), .OUT_done(done_a), .OUT_sclk(sclk_a), .OUT_cs(cs_a),
        .OUT_mosi(mosi_a), .IN_miso(in_miso)
    );

    spi_flash_burst_reader #(.WORD_W(8), .CMD(8'h0B), .DUMMY_CYCLES(9)) dut_b (
        .clk(clk), .rst(rst), .IN_addr(in_addr), .IN_len(in_len), .IN_read(read_b),
        .IN_cancel(in_cancel), .OUT_ready(ready_b), .OUT_busy(busy_b), .OUT_word(word_b),
        .OUT_word_valid(valid_b), .OUT_done(done_b), .OUT_sclk(sclk_b), .OUT_cs(cs_b),
        .OUT_mosi(mosi_b), .IN_miso(in_miso)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Flash model and monitor state
    logic [31:0] flash_words [16];
    logic [31:0] hdr = '0;
    int          cyc = 0, k = -1, burst_start = 0;
    int          low_len_last = 0, high_run = 0, high_run_last = 0, bursts = 0;
    int          n_done = 0, done_cyc = 0, guard_cnt = 0, mosi_err = 0, ready_err = 0;
    int          cancel_at = -1;
    int          strobe_cyc [$];
    logic [31:0] strobe_word [$];

    initial begin
        in_miso   = 1'b0;
        in_cancel = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (!obs_cs) begin
                if (k < 0) begin
                    k             = 0;
                    burst_start   = cyc;
                    high_run_last = high_run;
                end else begin
                    k++;
                end
            end else begin
                if (k >= 0) begin
                    low_len_last = k + 1;
                    bursts++;
                    k        = -1;
                    high_run = 0;
                end
                high_run++;
            end
            if (obs_valid) begin
                strobe_cyc.push_back(cyc);
                strobe_word.push_back(obs_word);
            end
            if (obs_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (obs_busy && obs_cs) guard_cnt++;
            if (obs_ready == obs_busy) ready_err++;
            in_cancel = (k >= 0 && k == cancel_at);
            #5;
            if (k >= 0 && k < HDR) hdr = {hdr[30:0], obs_mosi};
            else if (obs_mosi) mosi_err++;
            if (k >= HDR + p_d) begin
                int j;
                j = k - HDR - p_d;
                in_miso = flash_words[(j / p_w) % 16][p_w - 1 - (j % p_w)];
            end else begin
                in_miso = 1'($urandom);
            end
        end
    end

    task automatic fill(input logic s);
        for (int i = 0; i < 16; i++) flash_words[i] = s ? ($urandom & 32'hff) : $urandom;
    endtask

    task automatic clear_log();
        strobe_cyc.delete();
        strobe_word.delete();
        n_done    = 0;
        guard_cnt = 0;
        mosi_err  = 0;
        ready_err = 0;
    endtask

    task automatic run_burst(input logic s, input logic [23:0] a, input logic [15:0] len,
                             input int cancel_k, input string tag);
        int base, tmo, nw, low, dn, dc, w, d;
        @(posedge clk);
        #3;
        sel = s;
        clear_log();
        cancel_at = cancel_k;
        base      = bursts;
        in_addr   = a;
        in_len    = len;
        in_read   = 1'b1;
        @(posedge clk);
        #3;
        in_read = 1'b0;
        tmo = 1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #4;
            if (bursts > base && obs_ready) begin
                tmo = 0;
                break;
            end
        end
        check({tag, "_timeout"}, tmo, 0);
        w = p_w;
        d = p_d;
        if (cancel_k < 0) begin
            nw  = int'(len);
            low = HDR + d + int'(len) * w;
            dn  = 1;
        end else begin
            dc  = cancel_k - (HDR + d) + 1;
            nw  = (dc > 0) ? dc / w : 0;
            if (len != 0 && nw > int'(len)) nw = int'(len);
            low = cancel_k + 1;
            dn  = 0;
        end
        check({tag, "_cs_low_len"}, low_len_last, low);
        if (low >= HDR) check({tag, "_mosi_hdr"}, hdr, {p_cmd, a});
        check({tag, "_n_words"}, strobe_word.size(), nw);
        for (int i = 0; i < nw && i < strobe_word.size(); i++) begin
            check($sformatf("%s_word%0d", tag, i), strobe_word[i], flash_words[i]);
            check($sformatf("%s_time%0d", tag, i), strobe_cyc[i] - burst_start, HDR + d + (i + 1) * w);
        end
        check({tag, "_n_done"}, n_done, dn);
        if (dn != 0 && strobe_cyc.size() > 0) check({tag, "_done_time"}, done_cyc, strobe_cyc[$]);
        check({tag, "_guard"}, guard_cnt, GUARD);
        check({tag, "_mosi_idle"}, mosi_err, 0);
        check({tag, "_ready_busy"}, ready_err, 0);
        cancel_at = -1;
    endtask

    initial begin
        int          base, tmo, tot, ck;
        logic        s;
        logic [15:0] len;
        logic [23:0] a;
        rst     = 1'b0;
        in_read = 1'b0;
        in_addr = '0;
        in_len  = '0;
        sel     = 1'b0;
        #23;
        rst = 1'b1;

        // Reset state of both variants
        for (int v = 0; v < 2; v++) begin
            @(posedge clk);
            #3;
            sel = 1'(v);
            #1;
            check($sformatf("rst%0d_cs", v), 32'(obs_cs), 1);
            check($sformatf("rst%0d_mosi", v), 32'(obs_mosi), 0);
            check($sformatf("rst%0d_word", v), obs_word, 0);
            check($sformatf("rst%0d_valid", v), 32'(obs_valid), 0);
            check($sformatf("rst%0d_done", v), 32'(obs_done), 0);
            check($sformatf("rst%0d_busy", v), 32'(obs_busy), 0);
            check($sformatf("rst%0d_ready", v), 32'(obs_ready), 1);
            check($sformatf("rst%0d_sclk", v), 32'(obs_sclk), 32'(clk));
        end

        // Fixed-length read
        flash_words[0] = 32'hDEADBEEF;
        flash_words[1] = 32'hCAFEF00D;
        run_burst(1'b0, 24'h012345, 16'd2, -1, "fixed");

        // Unlimited read cancelled mid 6th word
        fill(1'b0);
        run_burst(1'b0, 24'($urandom), 16'd0, HDR + 1 + 5 * 32 + 16, "unlim_cancel");

        // Cancel on the cycle completing word 3
        fill(1'b0);
        run_burst(1'b0, 24'($urandom), 16'd0, HDR + 1 + 3 * 32 - 1, "cancel_edge");

        // Byte-wide fast-read variant
        fill(1'b1);
        flash_words[0] = 32'hA5;
        flash_words[1] = 32'h5A;
        run_burst(1'b1, 24'($urandom), 16'd2, -1, "fast8");

        // Randomized bursts, some cancelled at an arbitrary cycle
        for (int r = 0; r < 6; r++) begin
            s   = 1'($urandom_range(0, 1));
            len = 16'($urandom_range(1, 3));
            a   = 24'($urandom);
            fill(s);
            tot = HDR + (s ? 9 : 1) + int'(len) * (s ? 8 : 32);
            ck  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, tot - 2)) : -1;
            run_burst(s, a, len, ck, $sformatf("rand%0d", r));
        end

        // Back-to-back: IN_read held high
        @(posedge clk);
        #3;
        sel = 1'b0;
        fill(1'b0);
        clear_log();
        base    = bursts;
        a       = 24'($urandom);
        in_addr = a;
        in_len  = 16'd1;
        in_read = 1'b1;
        tmo     = 1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #4;
            if (bursts >= base + 2) begin
                tmo = 0;
                break;
            end
        end
        in_read = 1'b0;
        check("b2b_timeout", tmo, 0);
        tmo = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #4;
            if (obs_ready) begin
                tmo = 0;
                break;
            end
        end
        check("b2b_idle_timeout", tmo, 0);
        check("b2b_bursts", bursts - base, 2);
        check("b2b_gap", high_run_last, GUARD + 1);
        check("b2b_low_len", low_len_last, HDR + 1 + 32);
        check("b2b_hdr", hdr, {8'h03, a});
        check("b2b_n_words", strobe_word.size(), 2);
        if (strobe_word.size() == 2) begin
            check("b2b_word0", strobe_word[0], flash_words[0]);
            check("b2b_word1", strobe_word[1], flash_words[0]);
        end

        // Asynchronous reset during DATA, on a strobe cycle
        @(posedge clk);
        #3;
        sel = 1'b0;
        fill(1'b0);
        in_addr = 24'($urandom);
        in_len  = 16'd4;
        in_read = 1'b1;
        @(posedge clk);
        #3;
        in_read = 1'b0;
        tmo = 1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #4;
            if (obs_valid) begin
                tmo = 0;
                break;
            end
        end
        check("mid_rst_timeout", tmo, 0);
        rst = 1'b0;
        #1;
        check("mid_rst_cs", 32'(obs_cs), 1);
        check("mid_rst_valid", 32'(obs_valid), 0);
        check("mid_rst_done", 32'(obs_done), 0);
        check("mid_rst_busy", 32'(obs_busy), 0);
        check("mid_rst_word", obs_word, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #3;
        check("post_rst_ready", 32'(obs_ready), 1);
        check("post_rst_cs", 32'(obs_cs), 1);
        fill(1'b0);
        run_burst(1'b0, 24'($urandom), 16'd2, -1, "post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
